// File: rtl/cim_if_decode.sv
// CIM instruction fetch/decode front end: valid/ready intake, decode, and a
// 4-stage control delay line (LD +1, STD/CIM +2, NMC +3, WB +4) with stall/flush.
module cim_if_decode #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_ACT  = 3,
  parameter int unsigned CORE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instruction,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              stall,
  input  logic              flush,
  output logic              weight_we,
  output logic [ADDR_W-1:0] weight_in_A,
  output logic [N_ACT-1:0]  act_we,
  output logic [ADDR_W-1:0] act_in_A,
  output logic              STDW,
  output logic              STDR,
  output logic [ADDR_W-1:0] STD_A,
  output logic              CIM_en,
  output logic              slide_en,
  output logic [CORE_W-1:0] CIM_Core_A,
  output logic              relu_out_en,
  output logic              WB_en,
  output logic [ADDR_W-1:0] WB_A,
  output logic              illegal_op
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_rem, w_rem_nxt;
  logic [CORE_W-1:0] r_core, w_core_nxt;
  logic              r_illegal;

  // stage 1: LD consumers plus everything carried downstream
  logic              r_s1_v, r_s1_ldw, r_s1_lda, r_s1_stdw, r_s1_stdr;
  logic              r_s1_cim, r_s1_slide, r_s1_relu, r_s1_wb;
  logic [3:0]        r_s1_ch;
  logic [CORE_W-1:0] r_s1_core;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s2_v, r_s2_stdw, r_s2_stdr, r_s2_cim, r_s2_slide, r_s2_relu, r_s2_wb;
  logic [CORE_W-1:0] r_s2_core;
  logic [ADDR_W-1:0] r_s2_addr;
  logic              r_s3_v, r_s3_relu, r_s3_wb;
  logic [ADDR_W-1:0] r_s3_addr;
  logic              r_s4_v, r_s4_wb;
  logic [ADDR_W-1:0] r_s4_addr;

  logic              w_accept, w_ld, w_illegal;
  logic              w_ldw, w_lda, w_stdw, w_stdr, w_cim, w_slide, w_relu, w_wb;
  logic [3:0]        w_op, w_f, w_ch;
  logic [CORE_W-1:0] w_core;
  logic [ADDR_W-1:0] w_addr;
  logic              w_act_en, w_gate;

  assign w_op        = instruction[7:4];
  assign w_f         = instruction[3:0];
  assign instr_ready = (r_state == S_IDLE) & ~stall & ~flush;
  assign w_accept    = instr_valid & instr_ready;

  // next-state, burst counter and stage-1 load decode
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_core_nxt  = r_core;
    w_ld        = 1'b0;
    w_illegal   = 1'b0;
    w_ldw       = 1'b0;
    w_lda       = 1'b0;
    w_stdw      = 1'b0;
    w_stdr      = 1'b0;
    w_cim       = 1'b0;
    w_slide     = 1'b0;
    w_relu      = 1'b0;
    w_wb        = 1'b0;
    w_ch        = 4'd0;
    w_core      = '0;
    w_addr      = '0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
    end else if (!stall) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_ld   = 1'b1;
            w_addr = address;
            case (w_op)
              4'd0: ;
              4'd1: w_ldw = 1'b1;
              4'd2: begin
                if (32'(w_f) < N_ACT) begin
                  w_lda = 1'b1;
                  w_ch  = w_f;
                end else begin
                  w_illegal = 1'b1;
                end
              end
              4'd3: w_stdw = 1'b1;
              4'd4: w_stdr = 1'b1;
              4'd5: begin
                w_cim  = 1'b1;
                w_core = w_f[CORE_W-1:0];
              end
              4'd6: begin
                w_cim  = 1'b1;
                w_core = w_f[CORE_W-1:0];
                if (data != '0) begin
                  w_state_nxt = S_BURST;
                  w_rem_nxt   = data;
                  w_core_nxt  = w_f[CORE_W-1:0];
                end
              end
              4'd7: begin
                w_relu = data[0];
                w_wb   = 1'b1;
              end
              default: w_illegal = 1'b1;
            endcase
          end
        end
        S_BURST: begin
          w_ld      = 1'b1;
          w_cim     = 1'b1;
          w_slide   = 1'b1;
          w_core    = r_core;
          w_rem_nxt = r_rem - DATA_W'(1);
          if (r_rem == DATA_W'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_core  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_core  <= w_core_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else if (w_illegal) r_illegal <= 1'b1;
  end

  // control delay line; flush clears valids, stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0; r_s1_ldw <= 1'b0; r_s1_lda <= 1'b0; r_s1_stdw <= 1'b0;
      r_s1_stdr <= 1'b0; r_s1_cim <= 1'b0; r_s1_slide <= 1'b0; r_s1_relu <= 1'b0;
      r_s1_wb <= 1'b0; r_s1_ch <= 4'd0; r_s1_core <= '0; r_s1_addr <= '0;
      r_s2_v <= 1'b0; r_s2_stdw <= 1'b0; r_s2_stdr <= 1'b0; r_s2_cim <= 1'b0;
      r_s2_slide <= 1'b0; r_s2_relu <= 1'b0; r_s2_wb <= 1'b0; r_s2_core <= '0;
      r_s2_addr <= '0;
      r_s3_v <= 1'b0; r_s3_relu <= 1'b0; r_s3_wb <= 1'b0; r_s3_addr <= '0;
      r_s4_v <= 1'b0; r_s4_wb <= 1'b0; r_s4_addr <= '0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
      r_s4_v <= 1'b0;
    end else if (!stall) begin
      r_s1_v <= w_ld; r_s1_ldw <= w_ldw; r_s1_lda <= w_lda; r_s1_stdw <= w_stdw;
      r_s1_stdr <= w_stdr; r_s1_cim <= w_cim; r_s1_slide <= w_slide;
      r_s1_relu <= w_relu; r_s1_wb <= w_wb; r_s1_ch <= w_ch; r_s1_core <= w_core;
      r_s1_addr <= w_addr;
      r_s2_v <= r_s1_v; r_s2_stdw <= r_s1_stdw; r_s2_stdr <= r_s1_stdr;
      r_s2_cim <= r_s1_cim; r_s2_slide <= r_s1_slide; r_s2_relu <= r_s1_relu;
      r_s2_wb <= r_s1_wb; r_s2_core <= r_s1_core; r_s2_addr <= r_s1_addr;
      r_s3_v <= r_s2_v; r_s3_relu <= r_s2_relu; r_s3_wb <= r_s2_wb;
      r_s3_addr <= r_s2_addr;
      r_s4_v <= r_s3_v; r_s4_wb <= r_s3_wb; r_s4_addr <= r_s3_addr;
    end
  end

  assign w_gate      = ~stall;
  assign weight_we   = r_s1_v & r_s1_ldw & w_gate;
  assign weight_in_A = weight_we ? r_s1_addr : '0;
  assign w_act_en    = r_s1_v & r_s1_lda & w_gate;
  assign act_we      = w_act_en ? (N_ACT'(1) << r_s1_ch) : '0;
  assign act_in_A    = w_act_en ? r_s1_addr : '0;
  assign STDW        = r_s2_v & r_s2_stdw & w_gate;
  assign STDR        = r_s2_v & r_s2_stdr & w_gate;
  assign STD_A       = (STDW | STDR) ? r_s2_addr : '0;
  assign CIM_en      = r_s2_v & r_s2_cim & w_gate;
  assign slide_en    = CIM_en & r_s2_slide;
  assign CIM_Core_A  = CIM_en ? r_s2_core : '0;
  assign relu_out_en = r_s3_v & r_s3_relu & w_gate;
  assign WB_en       = r_s4_v & r_s4_wb & w_gate;
  assign WB_A        = WB_en ? r_s4_addr : '0;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_cim_if_decode.sv
// Directed-vector bench for cim_if_decode; all outputs compared each cycle
// against hand-derived expectations.
module tb_cim_if_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instruction;
  logic [7:0] address;
  logic [7:0] data;
  logic       stall;
  logic       flush;
  logic       weight_we;
  logic [7:0] weight_in_A;
  logic [2:0] act_we;
  logic [7:0] act_in_A;
  logic       STDW, STDR;
  logic [7:0] STD_A;
  logic       CIM_en, slide_en;
  logic [1:0] CIM_Core_A;
  logic       relu_out_en, WB_en;
  logic [7:0] WB_A;
  logic       illegal_op;

  typedef struct packed {
    logic       we;
    logic [7:0] wa;
    logic [2:0] actwe;
    logic [7:0] acta;
    logic       stdw;
    logic       stdr;
    logic [7:0] stda;
    logic       cim;
    logic       slide;
    logic [1:0] core;
    logic       relu;
    logic       wben;
    logic [7:0] wba;
    logic       rdy;
    logic       ill;
  } out_t;

  out_t obs, e;
  logic ill_exp;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cim_if_decode #(.ADDR_W(8), .DATA_W(8), .N_ACT(3), .CORE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .address(address), .data(data), .stall(stall),
    .flush(flush), .weight_we(weight_we), .weight_in_A(weight_in_A),
    .act_we(act_we), .act_in_A(act_in_A), .STDW(STDW), .STDR(STDR), .STD_A(STD_A),
    .CIM_en(CIM_en), .slide_en(slide_en), .CIM_Core_A(CIM_Core_A),
    .relu_out_en(relu_out_en), .WB_en(WB_en), .WB_A(WB_A), .illegal_op(illegal_op)
  );

  assign obs = {weight_we, weight_in_A, act_we, act_in_A, STDW, STDR, STD_A,
                CIM_en, slide_en, CIM_Core_A, relu_out_en, WB_en, WB_A,
                instr_ready, illegal_op};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] ins, input logic [7:0] a,
                     input logic [7:0] d);
    instr_valid = v;
    instruction = ins;
    address     = a;
    data        = d;
  endtask

  task automatic idle_e();
    e     = '0;
    e.rdy = 1'b1;
    e.ill = ill_exp;
  endtask

  // check the current cycle mid-period, then advance just past the next edge
  task automatic cyc(input string tag);
    @(negedge clk);
    chk(tag, 64'(obs), 64'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ill_exp = 1'b0;
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    idle_e(); cyc("rst_hold0");
    idle_e(); cyc("rst_hold1");
    rst_n = 1'b1;
    idle_e(); cyc("post_rst");

    // WB with relu
    drv(1'b1, 8'h70, 8'h2A, 8'h01); idle_e(); cyc("wb_acc");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); cyc("wb_p1");
    idle_e(); cyc("wb_p2");
    idle_e(); e.relu = 1'b1; cyc("wb_relu");
    idle_e(); e.wben = 1'b1; e.wba = 8'h2A; cyc("wb_en");
    idle_e(); cyc("wb_done");

    // back-to-back LDW, LDA ch2, STDW, CIM core1, STDR
    drv(1'b1, 8'h10, 8'h10, 8'h00); idle_e(); cyc("b2b_c0");
    drv(1'b1, 8'h22, 8'h20, 8'h00); idle_e(); e.we = 1'b1; e.wa = 8'h10; cyc("b2b_ldw");
    drv(1'b1, 8'h30, 8'h30, 8'h00); idle_e(); e.actwe = 3'b100; e.acta = 8'h20; cyc("b2b_lda");
    drv(1'b1, 8'h51, 8'h77, 8'h00); idle_e(); cyc("b2b_c3");
    drv(1'b1, 8'h40, 8'h44, 8'h00); idle_e(); e.stdw = 1'b1; e.stda = 8'h30; cyc("b2b_stdw");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); e.cim = 1'b1; e.core = 2'd1; cyc("b2b_cim");
    idle_e(); e.stdr = 1'b1; e.stda = 8'h44; cyc("b2b_stdr");
    idle_e(); cyc("b2b_done");

    // CIMS core3 data3 with a held LDW behind it
    drv(1'b1, 8'h63, 8'h00, 8'h03); idle_e(); cyc("cims_acc");
    drv(1'b1, 8'h10, 8'h55, 8'h00); idle_e(); e.rdy = 1'b0; cyc("cims_r1");
    idle_e(); e.rdy = 1'b0; e.cim = 1'b1; e.core = 2'd3; cyc("cims_rep0");
    idle_e(); e.rdy = 1'b0; e.cim = 1'b1; e.core = 2'd3; e.slide = 1'b1; cyc("cims_rep1");
    idle_e(); e.cim = 1'b1; e.core = 2'd3; e.slide = 1'b1; cyc("cims_rep2");
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    idle_e(); e.cim = 1'b1; e.core = 2'd3; e.slide = 1'b1; e.we = 1'b1; e.wa = 8'h55;
    cyc("cims_rep3_ldw");
    idle_e(); cyc("cims_done");

    // stall 2 cycles while WB sits in stage 2
    drv(1'b1, 8'h71, 8'h3C, 8'h01); idle_e(); cyc("stl_acc");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); cyc("stl_s1");
    stall = 1'b1; idle_e(); e.rdy = 1'b0; cyc("stl_k0");
    idle_e(); e.rdy = 1'b0; cyc("stl_k1");
    stall = 1'b0; idle_e(); cyc("stl_s2");
    idle_e(); e.relu = 1'b1; cyc("stl_relu");
    idle_e(); e.wben = 1'b1; e.wba = 8'h3C; cyc("stl_wb");
    idle_e(); cyc("stl_done");

    // stall gates a live LD enable, which then reappears once
    drv(1'b1, 8'h10, 8'h66, 8'h00); idle_e(); cyc("stg_acc");
    drv(1'b0, 8'h00, 8'h00, 8'h00); stall = 1'b1; idle_e(); e.rdy = 1'b0; cyc("stg_gated");
    stall = 1'b0; idle_e(); e.we = 1'b1; e.wa = 8'h66; cyc("stg_release");
    idle_e(); cyc("stg_done");

    // flush during CIMS core2 data5 at repetition 2
    drv(1'b1, 8'h62, 8'h00, 8'h05); idle_e(); cyc("fl_acc");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); e.rdy = 1'b0; cyc("fl_r1");
    idle_e(); e.rdy = 1'b0; e.cim = 1'b1; e.core = 2'd2; cyc("fl_rep0");
    flush = 1'b1; idle_e(); e.rdy = 1'b0; e.cim = 1'b1; e.core = 2'd2; e.slide = 1'b1;
    cyc("fl_rep1");
    flush = 1'b0; drv(1'b1, 8'h51, 8'h00, 8'h00); idle_e(); cyc("fl_idle");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); cyc("fl_nocim");
    idle_e(); e.cim = 1'b1; e.core = 2'd1; cyc("fl_newcim");
    idle_e(); cyc("fl_done");

    // opcode 0xF then LDA ch5: illegal, sticky through a legal LDW
    drv(1'b1, 8'hF0, 8'h12, 8'h00); idle_e(); cyc("ill_acc");
    ill_exp = 1'b1;
    drv(1'b1, 8'h25, 8'h34, 8'h00); idle_e(); cyc("ill_set");
    drv(1'b1, 8'h10, 8'h77, 8'h00); idle_e(); cyc("ill_lda");
    drv(1'b0, 8'h00, 8'h00, 8'h00); idle_e(); e.we = 1'b1; e.wa = 8'h77; cyc("ill_ldw");
    idle_e(); cyc("ill_sticky");

    // asynchronous reset mid-stream (burst active, WB in flight)
    drv(1'b1, 8'h10, 8'h11, 8'h00); idle_e(); cyc("mr_acc");
    drv(1'b1, 8'h71, 8'h22, 8'h01); idle_e(); e.we = 1'b1; e.wa = 8'h11; cyc("mr_ldw");
    drv(1'b1, 8'h61, 8'h00, 8'h04); idle_e(); cyc("mr_wb");
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    idle_e(); e.rdy = 1'b0; chk("mr_burst", 64'(obs), 64'(e));
    #2 rst_n = 1'b0;
    #1 ill_exp = 1'b0; idle_e(); chk("mr_async", 64'(obs), 64'(e));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_e(); cyc("mr_post0");
    idle_e(); cyc("mr_post1");
    idle_e(); cyc("mr_post2");
    idle_e(); cyc("mr_post3");

    // NOP leaves illegal clear; opcode 8 sets it
    drv(1'b1, 8'h00, 8'h5A, 8'hFF); idle_e(); cyc("nop_acc");
    drv(1'b1, 8'h80, 8'h5B, 8'h00); idle_e(); cyc("nop_s1");
    drv(1'b0, 8'h00, 8'h00, 8'h00); ill_exp = 1'b1; idle_e(); cyc("op8_ill");
    idle_e(); cyc("op8_sticky");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
